// File: rtl/dp_ram_obi_if.sv
// OBI-style request/grant/response port bundle for dp_ram_obi.
// The master drives the request side; the RAM (slave) drives grant and response.
interface dp_ram_obi_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dp_ram_obi.sv
// Dual-port word RAM with two OBI-style ports and a 1- or 2-cycle read pipeline.
// Port A wins same-address write-write collisions by stalling port B.
// A read on one port that hits the word the other port writes in the same
// cycle returns the merged (post-write) word.
module dp_ram_obi #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input logic           clk,
  input logic           rst_i,
  dp_ram_obi_if.slave   a,
  dp_ram_obi_if.slave   b
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned NB    = DATA_WIDTH / 8;

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_read_latency
      $error("dp_ram_obi: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
      $error("dp_ram_obi: DATA_WIDTH must be a multiple of 8");
    end
  endgenerate

  // Port signals gathered into 2-entry arrays (index 0 = A, 1 = B)
  logic [1:0]            req;
  logic [1:0]            we;
  logic [ADDR_WIDTH-1:0] addr   [2];
  logic [NB-1:0]         be     [2];
  logic [DATA_WIDTH-1:0] wdata  [2];
  logic [1:0]            gnt;
  logic [1:0]            wr_en;
  logic [1:0]            rd_en;
  logic                  ww_collide;
  logic [DATA_WIDTH-1:0] rd_word [2];
  logic [1:0]            rvalid;
  logic [DATA_WIDTH-1:0] rdata  [2];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign req[0]   = a.req;
  assign we[0]    = a.we;
  assign addr[0]  = a.addr;
  assign be[0]    = a.be;
  assign wdata[0] = a.wdata;
  assign req[1]   = b.req;
  assign we[1]    = b.we;
  assign addr[1]  = b.addr;
  assign be[1]    = b.be;
  assign wdata[1] = b.wdata;

  assign a.gnt    = gnt[0];
  assign a.rvalid = rvalid[0];
  assign a.rdata  = rdata[0];
  assign b.gnt    = gnt[1];
  assign b.rvalid = rvalid[1];
  assign b.rdata  = rdata[1];

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         byte_en
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int unsigned k = 0; k < NB; k++) begin
      if (byte_en[k]) res[k*8 +: 8] = new_word[k*8 +: 8];
    end
    return res;
  endfunction

  // Grant: A always, B stalled only on a same-address write-write; none in reset
  always_comb begin
    gnt        = '0;
    ww_collide = req[0] & we[0] & req[1] & we[1] & (addr[0] == addr[1]);
    if (!rst_i) begin
      gnt[0] = req[0];
      gnt[1] = req[1] & ~ww_collide;
    end
    wr_en = gnt & we;
    rd_en = gnt & ~we;
  end

  // Array write; B is applied first so A would take precedence on a shared word
  always_ff @(posedge clk) begin
    if (wr_en[1]) mem[addr[1]] <= merge_bytes(mem[addr[1]], wdata[1], be[1]);
    if (wr_en[0]) mem[addr[0]] <= merge_bytes(mem[addr[0]], wdata[0], be[0]);
  end

  // Array read with the other port's same-cycle write merged in
  always_comb begin
    rd_word[0] = mem[addr[0]];
    rd_word[1] = mem[addr[1]];
    if (wr_en[1] && (addr[1] == addr[0]))
      rd_word[0] = merge_bytes(rd_word[0], wdata[1], be[1]);
    if (wr_en[0] && (addr[0] == addr[1]))
      rd_word[1] = merge_bytes(rd_word[1], wdata[0], be[0]);
  end

  generate
    for (genvar p = 0; p < 2; p++) begin : g_port
      logic                  s1_valid_q, s1_valid_d;
      logic [DATA_WIDTH-1:0] s1_data_q,  s1_data_d;

      // First response stage: every grant responds, data only loads on reads
      always_comb begin
        s1_valid_d = gnt[p];
        s1_data_d  = rd_en[p] ? rd_word[p] : s1_data_q;
      end

      // First response stage registers, flushed by reset
      always_ff @(posedge clk) begin
        if (rst_i) begin
          s1_valid_q <= 1'b0;
          s1_data_q  <= '0;
        end else begin
          s1_valid_q <= s1_valid_d;
          s1_data_q  <= s1_data_d;
        end
      end

      if (READ_LATENCY == 2) begin : g_lat2
        logic                  s1_read_q,  s1_read_d;
        logic                  s2_valid_q, s2_valid_d;
        logic [DATA_WIDTH-1:0] s2_data_q,  s2_data_d;

        // Output stage: data only advances when the first stage holds a read
        always_comb begin
          s1_read_d  = rd_en[p];
          s2_valid_d = s1_valid_q;
          s2_data_d  = (s1_valid_q && s1_read_q) ? s1_data_q : s2_data_q;
        end

        // Output stage registers, flushed by reset
        always_ff @(posedge clk) begin
          if (rst_i) begin
            s1_read_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
          end else begin
            s1_read_q  <= s1_read_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
          end
        end

        assign rvalid[p] = s2_valid_q;
        assign rdata[p]  = s2_data_q;
      end else begin : g_lat1
        assign rvalid[p] = s1_valid_q;
        assign rdata[p]  = s1_data_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_dp_ram_obi.sv
// Directed bench for dp_ram_obi: one instance at READ_LATENCY=1 (channels 0/1)
// and one at READ_LATENCY=2 (channels 2/3). Grants and read data are predicted
// from a reference memory; expected responses go into a scoreboard queue and
// are matched against rvalid/rdata on every falling edge.
module tb_dp_ram_obi;

  typedef struct {
    int          ch;
    int unsigned due;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_v;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  exp_t        sbq [$];
  logic [31:0] last_rdata [4];
  logic [31:0] mdl [2][256];

  logic        req_v  [4];
  logic        we_v   [4];
  logic [7:0]  addr_v [4];
  logic [3:0]  be_v   [4];
  logic [31:0] wd_v   [4];
  logic        gnt_obs [4];
  logic        rv_obs  [4];
  logic [31:0] rd_obs  [4];

  dp_ram_obi_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if1a ();
  dp_ram_obi_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if1b ();
  dp_ram_obi_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if2a ();
  dp_ram_obi_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if2b ();

  dp_ram_obi #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_i(rst_v), .a(if1a), .b(if1b)
  );
  dp_ram_obi #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst_i(rst_v), .a(if2a), .b(if2b)
  );

  assign if1a.req = req_v[0];  assign if1a.we = we_v[0];  assign if1a.addr = addr_v[0];
  assign if1a.be  = be_v[0];   assign if1a.wdata = wd_v[0];
  assign if1b.req = req_v[1];  assign if1b.we = we_v[1];  assign if1b.addr = addr_v[1];
  assign if1b.be  = be_v[1];   assign if1b.wdata = wd_v[1];
  assign if2a.req = req_v[2];  assign if2a.we = we_v[2];  assign if2a.addr = addr_v[2];
  assign if2a.be  = be_v[2];   assign if2a.wdata = wd_v[2];
  assign if2b.req = req_v[3];  assign if2b.we = we_v[3];  assign if2b.addr = addr_v[3];
  assign if2b.be  = be_v[3];   assign if2b.wdata = wd_v[3];

  assign gnt_obs[0] = if1a.gnt;  assign rv_obs[0] = if1a.rvalid;  assign rd_obs[0] = if1a.rdata;
  assign gnt_obs[1] = if1b.gnt;  assign rv_obs[1] = if1b.rvalid;  assign rd_obs[1] = if1b.rdata;
  assign gnt_obs[2] = if2a.gnt;  assign rv_obs[2] = if2a.rvalid;  assign rd_obs[2] = if2a.rdata;
  assign gnt_obs[3] = if2b.gnt;  assign rv_obs[3] = if2b.rvalid;  assign rd_obs[3] = if2b.rdata;

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (new_w & m) | (old_w & ~m);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(int ch, logic req, logic we, logic [7:0] addr, logic [3:0] be, logic [31:0] wd);
    req_v[ch] = req; we_v[ch] = we; addr_v[ch] = addr; be_v[ch] = be; wd_v[ch] = wd;
  endtask

  task automatic idle(int ch);
    drv(ch, 1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
  endtask

  // One clock cycle: check grants, push expected responses, update model
  task automatic tick();
    logic        g [4];
    logic [31:0] d;
    exp_t        e;
    int          o;
    bit          coll;
    bit          was_rst;
    #2;
    for (int ch = 0; ch < 4; ch++) begin
      o    = ch ^ 1;
      coll = (ch % 2 == 1) && req_v[o] && we_v[o] && req_v[ch] && we_v[ch] && (addr_v[o] == addr_v[ch]);
      g[ch] = req_v[ch] && !rst_v && !coll;
      n_assert++;
      assert (gnt_obs[ch] === g[ch]) else begin
        n_fail++;
        $error("FAIL gnt ch%0d cyc%0d: got %b expected %b", ch, cyc, gnt_obs[ch], g[ch]);
      end
    end
    for (int ch = 0; ch < 4; ch++) begin
      if (g[ch]) begin
        o = ch ^ 1;
        d = mdl[ch/2][addr_v[ch]];
        if (g[o] && we_v[o] && (addr_v[o] == addr_v[ch])) d = merge(d, wd_v[o], be_v[o]);
        e.ch   = ch;
        e.due  = cyc + ((ch < 2) ? 1 : 2);
        e.rd   = !we_v[ch];
        e.data = we_v[ch] ? 32'h0 : d;
        sbq.push_back(e);
      end
    end
    for (int ch = 0; ch < 4; ch++) begin
      if (g[ch] && we_v[ch]) mdl[ch/2][addr_v[ch]] = merge(mdl[ch/2][addr_v[ch]], wd_v[ch], be_v[ch]);
    end
    was_rst = rst_v;
    @(posedge clk);
    if (was_rst) begin
      sbq.delete();
      for (int ch = 0; ch < 4; ch++) last_rdata[ch] = 32'h0;
    end
    #1;
  endtask

  // Response monitor: rvalid exactly when a response is due, rdata holds between reads
  always @(negedge clk) begin
    bit hit;
    if (mon_en) begin
      for (int ch = 0; ch < 4; ch++) begin
        hit = 1'b0;
        for (int i = 0; i < sbq.size(); i++) begin
          if (!hit && sbq[i].ch == ch && sbq[i].due == cyc) begin
            hit = 1'b1;
            if (sbq[i].rd) last_rdata[ch] = sbq[i].data;
            sbq.delete(i);
          end
        end
        n_assert++;
        assert (rv_obs[ch] === hit) else begin
          n_fail++;
          $error("FAIL rvalid ch%0d cyc%0d: got %b expected %b", ch, cyc, rv_obs[ch], hit);
        end
        n_assert++;
        assert (rd_obs[ch] === last_rdata[ch]) else begin
          n_fail++;
          $error("FAIL rdata ch%0d cyc%0d: got %h expected %h", ch, cyc, rd_obs[ch], last_rdata[ch]);
        end
      end
    end
  end

  initial begin
    rst_v = 1'b1;
    for (int ch = 0; ch < 4; ch++) begin
      idle(ch);
      last_rdata[ch] = 32'h0;
    end
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Requests during reset are not granted
    drv(0, 1'b1, 1'b0, 8'h00, 4'h0, 32'h0);
    drv(3, 1'b1, 1'b1, 8'h01, 4'hF, 32'h1);
    tick(); tick();
    for (int ch = 0; ch < 4; ch++) idle(ch);
    rst_v = 1'b0;

    // Test 1: write then read back on A
    drv(0, 1'b1, 1'b1, 8'h10, 4'hF, 32'hDEADBEEF); tick();
    drv(0, 1'b1, 1'b0, 8'h10, 4'h0, 32'h0);        tick();
    chk("t1_rvalid", 32'(rv_obs[0]), 32'h1);
    chk("t1_rdata", rd_obs[0], 32'hDEADBEEF);
    idle(0); tick();

    // Test 2: byte enables
    drv(0, 1'b1, 1'b1, 8'h20, 4'hF, 32'h11223344); tick();
    drv(0, 1'b1, 1'b1, 8'h20, 4'h5, 32'hAABBCCDD); tick();
    drv(0, 1'b1, 1'b0, 8'h20, 4'h0, 32'h0);        tick();
    chk("t2_be_merge", rd_obs[0], 32'h11BB33DD);
    idle(0); tick();

    // Test 3: write-write collision, B stalls and holds its request
    drv(0, 1'b1, 1'b1, 8'h05, 4'hF, 32'h1);
    drv(1, 1'b1, 1'b1, 8'h05, 4'hF, 32'h2);
    tick();
    idle(0); tick();
    idle(1);
    drv(0, 1'b1, 1'b0, 8'h05, 4'h0, 32'h0); tick();
    chk("t3_final", rd_obs[0], 32'h00000002);
    idle(0); tick();

    // be=0 write still responds and changes nothing; same-address read-read
    drv(1, 1'b1, 1'b1, 8'h10, 4'h0, 32'hFFFFFFFF); tick();
    drv(0, 1'b1, 1'b0, 8'h10, 4'h0, 32'h0);
    drv(1, 1'b1, 1'b0, 8'h10, 4'h0, 32'h0);
    tick();
    chk("rr_a", rd_obs[0], 32'hDEADBEEF);
    chk("rr_b", rd_obs[1], 32'hDEADBEEF);
    idle(0); idle(1); tick();

    // Test 4: cross-port read during write
    drv(0, 1'b1, 1'b1, 8'h30, 4'hF, 32'h0); tick();
    drv(0, 1'b1, 1'b1, 8'h30, 4'hC, 32'hFFFF0000);
    drv(1, 1'b1, 1'b0, 8'h30, 4'h0, 32'h0);
    tick();
    chk("t4_rvalid", 32'(rv_obs[1]), 32'h1);
    chk("t4_rdata", rd_obs[1], 32'hFFFF0000);
    idle(0); idle(1); tick();

    // Test 5: READ_LATENCY=2 streaming on A, reverse stream on B
    for (int i = 0; i < 8; i++) begin
      drv(2, 1'b1, 1'b1, 8'(i), 4'hF, 32'(i * 3)); tick();
    end
    for (int i = 0; i < 8; i++) begin
      drv(2, 1'b1, 1'b0, 8'(i), 4'h0, 32'h0);
      drv(3, 1'b1, 1'b0, 8'(7 - i), 4'h0, 32'h0);
      tick();
      if (i >= 1) chk("t5_stream", rd_obs[2], 32'((i - 1) * 3));
    end
    idle(2); idle(3); tick();
    chk("t5_last", rd_obs[2], 32'd21);
    tick(); tick();

    // Test 6: reset while a read is in flight
    drv(2, 1'b1, 1'b0, 8'h05, 4'h0, 32'h0); tick();
    rst_v = 1'b1; tick();
    rst_v = 1'b0; idle(2);
    chk("t6_rdata_cleared", rd_obs[2], 32'h0);
    tick(); tick(); tick();
    drv(2, 1'b1, 1'b0, 8'h05, 4'h0, 32'h0);
    drv(0, 1'b1, 1'b0, 8'h10, 4'h0, 32'h0);
    tick();
    chk("t6_l1_intact", rd_obs[0], 32'hDEADBEEF);
    idle(2); idle(0); tick();
    chk("t6_l2_intact", rd_obs[2], 32'd15);
    tick(); tick();

    chk("sb_drained", 32'(sbq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
